fixed_bias_add_stream: RTL and testbench



---
 rtl/fixed_bias_add_stream.sv | 150 +++++++++++++++
 tb/tb_fixed_bias_add_stream.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_bias_add_stream.sv
// Joins a data stream with a bias stream, aligns the bias to the data format and adds per element.
// Results leave through a 2-entry skid buffer. Define BIAS_ADD_SATURATE_EN to clamp instead of wrap.
module fixed_bias_add_stream #(
   parameter int DATA_IN_PRECISION_0  = 32,
   parameter int DATA_IN_PRECISION_1  = 6,
   parameter int BIAS_PRECISION_0     = 16,
   parameter int BIAS_PRECISION_1     = 3,
   parameter int DATA_OUT_PRECISION_0 = 16,
   parameter int TENSOR_SIZE_DIM_0    = 32,
   parameter int PARALLELISM_DIM_0    = 1,
   parameter int OUT_DEPTH            = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM_DIM_0],
   input  logic                            data_in_valid,
   output logic                            data_in_ready,
   input  logic [BIAS_PRECISION_0-1:0]     bias [PARALLELISM_DIM_0],
   input  logic                            bias_valid,
   output logic                            bias_ready,
   output logic [DATA_OUT_PRECISION_0-1:0] data_out [PARALLELISM_DIM_0],
   output logic                            data_out_valid,
   input  logic                            data_out_ready,
   output logic                            data_out_last
);
   localparam int P     = PARALLELISM_DIM_0;
   localparam int OW    = DATA_OUT_PRECISION_0;
   localparam int SHIFT = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
   localparam int BW    = BIAS_PRECISION_0 + SHIFT;
   localparam int SW    = ((DATA_IN_PRECISION_0 > BW) ? DATA_IN_PRECISION_0 : BW) + 1;
   localparam int CW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   if (BIAS_PRECISION_1 > DATA_IN_PRECISION_1) begin : g_bad_frac
      $error("BIAS_PRECISION_1 must not exceed DATA_IN_PRECISION_1");
   end
   if ((TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0) != 0) begin : g_bad_par
      $error("PARALLELISM_DIM_0 must divide TENSOR_SIZE_DIM_0");
   end

   logic [OW-1:0]        out_data_q  [P];
   logic [OW-1:0]        out_data_d  [P];
   logic [OW-1:0]        skid_data_q [P];
   logic [OW-1:0]        skid_data_d [P];
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic                 skid_full_q, skid_full_d;
   logic                 skid_last_q, skid_last_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [OW-1:0]        res_w [P];
   logic signed [SW-1:0] d_ext, b_ext, sum_w;
   logic                 in_ready, fire, pop, last_w;

   assign in_ready      = !skid_full_q;
   assign fire          = data_in_valid & bias_valid & in_ready;
   assign data_in_ready = fire;
   assign bias_ready    = fire;
   assign pop           = out_valid_q & data_out_ready;
   assign last_w        = (cnt_q == CW'(OUT_DEPTH - 1));

`ifdef BIAS_ADD_SATURATE_EN
   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`else
   logic unused_sum_msbs;
`endif

   always_comb begin
      d_ext = '0;
      b_ext = '0;
      sum_w = '0;
`ifndef BIAS_ADD_SATURATE_EN
      unused_sum_msbs = 1'b0;
`endif
      for (int i = 0; i < P; i++) begin
         d_ext = {{(SW-DATA_IN_PRECISION_0){data_in[i][DATA_IN_PRECISION_0-1]}}, data_in[i]};
         b_ext = {{(SW-BIAS_PRECISION_0){bias[i][BIAS_PRECISION_0-1]}}, bias[i]};
         b_ext = b_ext <<< SHIFT;
         sum_w = d_ext + b_ext;
`ifdef BIAS_ADD_SATURATE_EN
         if (sum_w > SAT_MAX)
            res_w[i] = SAT_MAX[OW-1:0];
         else if (sum_w < SAT_MIN)
            res_w[i] = SAT_MIN[OW-1:0];
         else
            res_w[i] = sum_w[OW-1:0];
`else
         res_w[i] = sum_w[OW-1:0];
         unused_sum_msbs = unused_sum_msbs ^ (^sum_w[SW-1:OW]);
`endif
      end
   end

   // Output reg refills from skid first; a fire only lands in the skid reg when the output is stalled.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      skid_data_d = skid_data_q;
      skid_full_d = skid_full_q;
      skid_last_d = skid_last_q;
      cnt_d       = cnt_q;
      if (fire)
         cnt_d = last_w ? '0 : cnt_q + 1'b1;
      if (!out_valid_q || pop) begin
         if (skid_full_q) begin
            out_data_d  = skid_data_q;
            out_last_d  = skid_last_q;
            out_valid_d = 1'b1;
            skid_full_d = 1'b0;
         end else if (fire) begin
            out_data_d  = res_w;
            out_last_d  = last_w;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (fire) begin
         skid_data_d = res_w;
         skid_last_d = last_w;
         skid_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < P; i++) begin
            out_data_q[i]  <= '0;
            skid_data_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         skid_full_q <= 1'b0;
         skid_last_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         skid_data_q <= skid_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         skid_full_q <= skid_full_d;
         skid_last_q <= skid_last_d;
         cnt_q       <= cnt_d;
      end
   end

   assign data_out       = out_data_q;
   assign data_out_valid = out_valid_q;
   assign data_out_last  = out_last_q;

endmodule

// File: tb/tb_fixed_bias_add_stream.sv
// Directed bench for fixed_bias_add_stream: arithmetic, join, skid buffer, row-last flag and async reset.
// Expected overflow results follow BIAS_ADD_SATURATE_EN when it is defined.
module tb_fixed_bias_add_stream;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in [1];
   logic        data_in_valid;
   logic        data_in_ready;
   logic [15:0] bias [1];
   logic        bias_valid;
   logic        bias_ready;
   logic [15:0] data_out [1];
   logic        data_out_valid;
   logic        data_out_ready;
   logic        data_out_last;

   int errors = 0;
   int checks = 0;

`ifdef BIAS_ADD_SATURATE_EN
   localparam logic [15:0] OVF_POS = 16'h7FFF;
   localparam logic [15:0] OVF_NEG = 16'h8000;
`else
   localparam logic [15:0] OVF_POS = 16'h8040;
   localparam logic [15:0] OVF_NEG = 16'h7FC0;
`endif

   fixed_bias_add_stream dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_in_ready  (data_in_ready),
      .bias           (bias),
      .bias_valid     (bias_valid),
      .bias_ready     (bias_ready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .data_out_last  (data_out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1;
      data_in_valid = 1'b0;
      bias_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_one(input string tag, input logic [31:0] d, input logic [15:0] b,
                           input logic [15:0] exp);
      data_in[0] = d;
      bias[0] = b;
      data_in_valid = 1'b1;
      bias_valid = 1'b1;
      #1;
      check({tag, " rdy"}, 32'(data_in_ready & bias_ready), 32'd1);
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      bias_valid = 1'b0;
      check({tag, " vld"}, 32'(data_out_valid), 32'd1);
      check(tag, 32'(data_out[0]), 32'(exp));
   endtask

   function automatic logic [15:0] stream_exp(input int j);
      int e;
      e = (j * 100 - 3000) + (j - 20) * 8;
      return 16'(e);
   endfunction

   task automatic stream_rows(input int n);
      fork
         begin
            for (int k = 0; k < n; k++) begin
               logic acc;
               int tries;
               data_in[0] = 32'(k * 100 - 3000);
               bias[0] = 16'(k - 20);
               data_in_valid = 1'b1;
               bias_valid = 1'b1;
               acc = 1'b0;
               tries = 0;
               while (!acc && tries < 200) begin
                  @(negedge clk);
                  acc = data_in_ready & bias_ready;
                  @(posedge clk);
                  #1;
                  tries++;
               end
               if (!acc) begin
                  check("stream accept timeout", 32'(k), 32'(n));
                  break;
               end
            end
            data_in_valid = 1'b0;
            bias_valid = 1'b0;
         end
         begin
            int rx = 0;
            int cyc = 0;
            logic prev_stall = 1'b0;
            logic [15:0] prev_d = '0;
            logic prev_l = 1'b0;
            while (rx < n && cyc < 4000) begin
               @(negedge clk);
               cyc++;
               if (prev_stall) begin
                  check("stall valid", 32'(data_out_valid), 32'd1);
                  check("stall data", 32'(data_out[0]), 32'(prev_d));
                  check("stall last", 32'(data_out_last), 32'(prev_l));
               end
               if (data_out_valid && data_out_ready) begin
                  check($sformatf("stream data %0d", rx), 32'(data_out[0]), 32'(stream_exp(rx)));
                  check($sformatf("stream last %0d", rx), 32'(data_out_last),
                        32'((rx % 32) == 31));
                  rx++;
               end
               prev_stall = data_out_valid && !data_out_ready;
               prev_d = data_out[0];
               prev_l = data_out_last;
               @(posedge clk);
               #1;
               data_out_ready = 1'($urandom_range(0, 1));
            end
            if (rx < n) check("stream timeout", 32'(rx), 32'(n));
         end
      join
      data_out_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      data_in[0] = '0;
      bias[0] = '0;
      data_in_valid = 1'b0;
      bias_valid = 1'b0;
      data_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset valid", 32'(data_out_valid), 32'd0);
      check("reset last", 32'(data_out_last), 32'd0);
      check("reset data", 32'(data_out[0]), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      send_one("basic add", 32'h0000_0040, 16'h0010, 16'h00C0);
      send_one("negative", 32'hFFFF_FFC0, 16'hFFF8, 16'hFF80);
      send_one("overflow pos", 32'h0000_7FC0, 16'h0010, OVF_POS);
      send_one("overflow neg", 32'hFFFF_8040, 16'hFFF0, OVF_NEG);

      bias_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("lone bias data_rdy", 32'(data_in_ready), 32'd0);
         check("lone bias bias_rdy", 32'(bias_ready), 32'd0);
         @(posedge clk);
         #1;
         check("lone bias out", 32'(data_out_valid), 32'd0);
      end
      bias_valid = 1'b0;

      do_reset();
      stream_rows(64);
      repeat (3) @(posedge clk);

      do_reset();
      data_out_ready = 1'b0;
      data_in[0] = 32'h40;
      bias[0] = 16'h0;
      data_in_valid = 1'b1;
      bias_valid = 1'b1;
      #1;
      check("skid rdy 1st", 32'(data_in_ready), 32'd1);
      @(posedge clk);
      #1;
      data_in[0] = 32'h80;
      #1;
      check("skid rdy 2nd", 32'(data_in_ready), 32'd1);
      @(posedge clk);
      #1;
      data_in[0] = 32'hC0;
      #1;
      check("skid full data_rdy", 32'(data_in_ready), 32'd0);
      check("skid full bias_rdy", 32'(bias_ready), 32'd0);
      @(posedge clk);
      #1;
      check("skid still full", 32'(data_in_ready), 32'd0);
      check("skid head valid", 32'(data_out_valid), 32'd1);
      check("skid head data", 32'(data_out[0]), 32'h40);
      @(posedge clk);
      #1;
      check("skid head hold", 32'(data_out[0]), 32'h40);
      data_in_valid = 1'b0;
      bias_valid = 1'b0;
      data_out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("drain 2nd valid", 32'(data_out_valid), 32'd1);
      check("drain 2nd data", 32'(data_out[0]), 32'h80);
      @(posedge clk);
      #1;
      check("drain empty", 32'(data_out_valid), 32'd0);

      do_reset();
      data_in_valid = 1'b1;
      bias_valid = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         data_in[0] = 32'(k);
         @(posedge clk);
         #1;
      end
      check("pre-reset valid", 32'(data_out_valid), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("async rst valid", 32'(data_out_valid), 32'd0);
      check("async rst data", 32'(data_out[0]), 32'd0);
      check("async rst last", 32'(data_out_last), 32'd0);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("row2 valid %0d", i), 32'(data_out_valid), 32'd1);
         check($sformatf("row2 last %0d", i), 32'(data_out_last), 32'(i == 31));
      end
      data_in_valid = 1'b0;
      bias_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
